// File: rtl/minmax_sched.sv
// Round-robin front end that shares one 8x16 min/max finder between two requesters:
// collects an 8-word batch, bursts it into the finder, waits for Valid and reports.
module minmax_sched #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res_max,
    output logic [15:0] res_min,
    output logic        res_owner,
    output logic        res_err,
    output logic        busy,
    output logic        mm_write_en,
    output logic [2:0]  mm_write_reg,
    output logic [15:0] mm_write_data,
    input  logic [15:0] mm_max,
    input  logic [15:0] mm_min,
    input  logic        mm_valid
);

    typedef enum logic [2:0] {IDLE, COLLECT, BURST, WAIT, REPORT, RELEASE} state_t;

    state_t      state, state_nx;
    logic [15:0] batch_buf [8];
    logic [2:0]  idx, idx_nx;
    logic [7:0]  wait_cnt;
    logic        owner, owner_nx, last_owner;
    logic        take, cur_req;
    logic [15:0] cur_data;
    logic        we_nx;
    logic [2:0]  reg_nx;
    logic        finish;

    assign ack0 = (state == COLLECT) && !owner;
    assign ack1 = (state == COLLECT) && owner;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        owner_nx = owner;
        take     = 1'b0;
        cur_req  = owner ? req1 : req0;
        cur_data = owner ? data1 : data0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nx = (req0 && req1) ? ~last_owner : req1;
                    idx_nx   = '0;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (cur_req) begin
                    take   = 1'b1;
                    idx_nx = idx + 3'd1;
                    if (idx == 3'd7) state_nx = BURST;
                end
            end
            BURST: begin
                idx_nx = idx + 3'd1;
                if (idx == 3'd7) state_nx = WAIT;
            end
            WAIT: begin
                if (mm_valid || wait_cnt == 8'(TIMEOUT - 1)) state_nx = REPORT;
            end
            REPORT:  state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // finder outputs are registered, so they are derived from the state being entered
        we_nx  = (state_nx == BURST) || (state_nx == WAIT);
        reg_nx = (state_nx == BURST) ? idx_nx : (we_nx ? 3'd7 : 3'd0);
    end

    assign finish = (state == WAIT) && (state_nx == REPORT);

    always_ff @(posedge clk) begin
        if (take) batch_buf[idx] <= cur_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            wait_cnt      <= '0;
            mm_write_en   <= 1'b0;
            mm_write_reg  <= '0;
            mm_write_data <= '0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            res_max       <= '0;
            res_min       <= '0;
            res_owner     <= 1'b0;
            res_err       <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            owner         <= owner_nx;
            wait_cnt      <= (state == WAIT) ? wait_cnt + 8'd1 : '0;
            mm_write_en   <= we_nx;
            mm_write_reg  <= reg_nx;
            mm_write_data <= we_nx ? batch_buf[reg_nx] : '0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            if (finish) begin
                res_err    <= !mm_valid;
                res_max    <= mm_valid ? mm_max : '0;
                res_min    <= mm_valid ? mm_min : '0;
                res_owner  <= owner;
                last_owner <= owner;
                done0      <= !owner;
                done1      <= owner;
            end
        end
    end

endmodule
